// File: rtl/scroll_pos_gen.sv
// scroll_pos_gen: background scroll origin generator.
// The horizontal origin steps once per frame at the start of vertical blank.
// Scroll speed ramps up every ACCEL_FRAMES frames spent in RUN.
// The vertical origin is loaded on request and applied at the next frame boundary.
module scroll_pos_gen #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int V_BLANK      = 480,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 8,
    parameter int ACCEL_FRAMES = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  v_cnt,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        y_load,
    input  logic [8:0]  y_set,
    output logic [8:0]  pos_x,
    output logic [8:0]  pos_y,
    output logic [3:0]  speed,
    output logic [15:0] distance,
    output logic        running
);

    localparam int AW = $clog2(ACCEL_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_restart;
    logic          w_halt;
    logic          w_step;

    logic [9:0]    r_v_cnt;
    logic          w_tick;
    logic [8:0]    r_pos_x;
    logic [8:0]    r_pos_y;
    logic [3:0]    r_speed;
    logic [15:0]   r_distance;
    logic [AW-1:0] r_accel;
    logic          r_running;
    logic          r_y_pend;
    logic [8:0]    r_y_cap;
    logic [9:0]    w_sum;
    logic [9:0]    w_wrap;
    logic [8:0]    w_y_clamp;

    // Tick only on the first cycle v_cnt sits at V_BLANK, so a held count does not retrigger.
    assign w_tick    = (v_cnt == 10'(V_BLANK)) && (r_v_cnt != 10'(V_BLANK));
    // speed < WIDTH keeps the sum below 2*WIDTH, so one subtraction always wraps.
    assign w_sum     = {1'b0, r_pos_x} + {6'b0, r_speed};
    assign w_wrap    = w_sum - 10'(WIDTH);
    assign w_y_clamp = (y_set > 9'(HEIGHT - 1)) ? 9'(HEIGHT - 1) : y_set;

    // Next-state decode; any control pulse in RUN suppresses that cycle's frame step.
    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        w_halt    = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stop && start) begin
                    w_next    = S_RUN;
                    w_restart = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_next = S_IDLE;
                    w_halt = 1'b1;
                end else if (start) begin
                    w_restart = 1'b1;
                end else if (pause) begin
                    w_next = S_PAUSE;
                end else if (w_tick) begin
                    w_step = 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_next = S_IDLE;
                    w_halt = 1'b1;
                end else if (start) begin
                    w_next    = S_RUN;
                    w_restart = 1'b1;
                end else if (pause) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, running flag and the frame-tick detector history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_v_cnt   <= '0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == S_RUN);
            r_v_cnt   <= v_cnt;
        end
    end

    // Horizontal origin, speed ramp and distance counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pos_x    <= '0;
            r_speed    <= '0;
            r_distance <= '0;
            r_accel    <= '0;
        end else if (w_restart) begin
            r_pos_x    <= '0;
            r_speed    <= 4'(SPEED_INIT);
            r_distance <= '0;
            r_accel    <= '0;
        end else if (w_halt) begin
            r_speed    <= '0;
        end else if (w_step) begin
            r_pos_x <= (w_sum >= 10'(WIDTH)) ? w_wrap[8:0] : w_sum[8:0];
            if (r_distance != 16'hFFFF)
                r_distance <= r_distance + 16'd1;
            // The step above used the old speed; a new speed applies next frame.
            if (r_accel == AW'(ACCEL_FRAMES - 1)) begin
                r_accel <= '0;
                if (r_speed < 4'(SPEED_MAX))
                    r_speed <= r_speed + 4'd1;
            end else begin
                r_accel <= r_accel + AW'(1);
            end
        end
    end

    // Vertical origin: capture on request, apply at the next frame tick in any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pos_y  <= '0;
            r_y_pend <= 1'b0;
            r_y_cap  <= '0;
        end else begin
            if (w_tick && r_y_pend)
                r_pos_y <= r_y_cap;
            if (y_load) begin
                r_y_pend <= 1'b1;
                r_y_cap  <= w_y_clamp;
            end else if (w_tick) begin
                r_y_pend <= 1'b0;
            end
        end
    end

    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign speed    = r_speed;
    assign distance = r_distance;
    assign running  = r_running;

endmodule
